// File: rtl/mod241_pkg.sv
// Shared constants, types and helpers for the chunked mod-241 residue engine.
package mod241_pkg;

  localparam int unsigned MOD     = 241;
  localparam int unsigned RES_W   = 8;
  localparam int unsigned CHUNK_W = 6;

  // 2^(6k) mod 241 repeats with period 4
  localparam logic [RES_W-1:0] WEIGHT [4] = '{8'd1, 8'd64, 8'd240, 8'd177};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic [RES_W-1:0] add_mod241(input logic [RES_W-1:0] a,
                                                  input logic [RES_W-1:0] b);
    logic [RES_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 9'(MOD)) s = s - 9'(MOD);
    return s[RES_W-1:0];
  endfunction

endpackage

// File: rtl/mod241_chunk_sched_mulred.sv
// Combinational weighted-chunk reducer: (c * w) mod 241 via 256 = 15 (mod 241) folding.
module mod241_chunk_sched_mulred
  import mod241_pkg::*;
(
  input  logic [CHUNK_W-1:0] c_i,
  input  logic [RES_W-1:0]   w_i,
  output logic [RES_W-1:0]   r_o
);

  localparam int unsigned PROD_W  = 14;
  localparam int unsigned FOLD1_W = 11;
  localparam int unsigned FOLD2_W = 9;
  localparam int unsigned FOLD    = 15;

  logic [PROD_W-1:0]  prod;
  logic [FOLD1_W-1:0] fold1;
  logic [FOLD2_W-1:0] fold2;

  // prod <= 15120, fold1 <= 1140, fold2 <= 315 so one subtract finishes the job
  always_comb begin
    prod  = PROD_W'(c_i) * PROD_W'(w_i);
    fold1 = FOLD1_W'(prod[PROD_W-1:8]) * FOLD1_W'(FOLD) + FOLD1_W'(prod[7:0]);
    fold2 = FOLD2_W'(fold1[FOLD1_W-1:8]) * FOLD2_W'(FOLD) + FOLD2_W'(fold1[7:0]);
    if (fold2 >= FOLD2_W'(MOD)) r_o = RES_W'(fold2 - FOLD2_W'(MOD));
    else                        r_o = fold2[RES_W-1:0];
  end

endmodule

// File: rtl/mod241_chunk_sched.sv
// Sequential operand mod 241: one 6-bit chunk per cycle through a shared reducer.
// Define MOD241_PIPE_EN to register the reducer output ahead of the accumulator.
module mod241_chunk_sched
  import mod241_pkg::*;
#(
  parameter int unsigned W = 400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_residue,
  output logic             busy
);

  localparam int unsigned NCHUNK   = (W + CHUNK_W - 1) / CHUNK_W;
  localparam int unsigned OPW      = NCHUNK * CHUNK_W;
  localparam int unsigned IDX_BITS = $clog2(NCHUNK + 1);
  localparam int unsigned IDX_W    = (IDX_BITS < 2) ? 2 : IDX_BITS;
  localparam int unsigned NSLOT    = 1 << IDX_W;

  state_e             state_q, state_d;
  logic [OPW-1:0]     opnd_q, opnd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               in_ready_q, out_valid_q, busy_q;
  logic [CHUNK_W-1:0] chunk_tbl [NSLOT];
  logic [RES_W-1:0]   r_c;

  // Slots past the last chunk read as zero so the index never needs clamping
  always_comb begin
    for (int k = 0; k < NSLOT; k++) chunk_tbl[k] = '0;
    for (int k = 0; k < NCHUNK; k++) chunk_tbl[k] = opnd_q[k*CHUNK_W +: CHUNK_W];
  end

  mod241_chunk_sched_mulred u_mulred (
    .c_i (chunk_tbl[idx_q]),
    .w_i (WEIGHT[idx_q[1:0]]),
    .r_o (r_c)
  );

`ifdef MOD241_PIPE_EN
  logic [RES_W-1:0] rp_q, rp_d;
  logic             pv_q, pv_d;
`endif

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    res_d   = res_q;
`ifdef MOD241_PIPE_EN
    rp_d    = rp_q;
    pv_d    = pv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          opnd_d  = OPW'(in_data);
          idx_d   = '0;
          acc_d   = '0;
`ifdef MOD241_PIPE_EN
          pv_d    = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        idx_d = idx_q + IDX_W'(1);
`ifdef MOD241_PIPE_EN
        // First RUN cycle only primes the pipe; the extra last cycle drains it
        rp_d = r_c;
        pv_d = 1'b1;
        if (pv_q) acc_d = add_mod241(acc_q, rp_q);
        if (idx_q == IDX_W'(NCHUNK)) begin
          res_d   = acc_d;
          state_d = DONE;
        end
`else
        acc_d = add_mod241(acc_q, r_c);
        if (idx_q == IDX_W'(NCHUNK - 1)) begin
          res_d   = acc_d;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MOD241_PIPE_EN
      rp_q        <= '0;
      pv_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
`ifdef MOD241_PIPE_EN
      rp_q        <= rp_d;
      pv_q        <= pv_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_residue = res_q;
  assign busy        = busy_q;

endmodule
